// File: rtl/kyber_pkg.sv
// Shared Kyber constants, sampler FSM states and the cbd2_cal output nibble layout.
package kyber_pkg;

  localparam int unsigned KYBER_N            = 256;
  localparam int unsigned KYBER_Q            = 3329;
  localparam int unsigned CBD2_WORDS         = 32;
  localparam int unsigned CBD2_COEF_PER_WORD = 8;
  localparam int unsigned COEF_W             = 12;
  localparam int unsigned ADDR_W             = 8;
  localparam int unsigned WORD_W             = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } cbd2_state_e;

  // Bit offset of coefficient i (0..7) inside the cbd2_cal output word.
  function automatic logic [4:0] cbd2_nib_pos(input logic [2:0] i);
    logic [4:0] pos;
    case (i)
      3'd0:    pos = 5'd24;
      3'd1:    pos = 5'd28;
      3'd2:    pos = 5'd16;
      3'd3:    pos = 5'd20;
      3'd4:    pos = 5'd8;
      3'd5:    pos = 5'd12;
      3'd6:    pos = 5'd0;
      default: pos = 5'd4;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/cbd2_sampler_ctrl_if.sv
// PRF input stream, start/status and coefficient RAM write port of the CBD2 sampler.
interface cbd2_sampler_ctrl_if;
  import kyber_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  logic                din_valid;
  logic                din_ready;
  logic [WORD_W-1:0]   din;
  logic                coef_we;
  logic [ADDR_W-1:0]   coef_addr;
  logic [COEF_W-1:0]   coef_data;

  modport master (
    output start, din_valid, din,
    input  busy, done, din_ready, coef_we, coef_addr, coef_data
  );

  modport slave (
    input  start, din_valid, din,
    output busy, done, din_ready, coef_we, coef_addr, coef_data
  );

endinterface

// File: rtl/cbd2_cal.sv
// CBD(eta=2) datapath: turns one PRF word into 8 signed 4-bit coefficients, registered on set.
module cbd2_cal
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] coefs;

  // Coefficient j = (b0+b1)-(b2+b3) over input nibble j, packed at its output slot.
  always_comb begin
    coefs = '0;
    for (int unsigned j = 0; j < CBD2_COEF_PER_WORD; j++) begin
      logic [3:0] src;
      logic [3:0] c;
      src   = 4'(din >> (4 * j));
      c     = 4'(src[0]) + 4'(src[1]) - 4'(src[2]) - 4'(src[3]);
      coefs = coefs | (WORD_W'(c) << cbd2_nib_pos(3'(j)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (set) begin
      dout <= coefs;
    end
  end

endmodule

// File: rtl/cbd2_sampler_ctrl.sv
// Sequences cbd2_cal to sample one 256-coefficient Kyber polynomial into the poly RAM.
// Build option CBD2_MODQ_EN: emit coefficients reduced into [0, Q) instead of sign-extended.
module cbd2_sampler_ctrl
  import kyber_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cbd2_sampler_ctrl_if.slave  bus
);

  cbd2_state_e       state, state_nx;
  logic [4:0]        word, word_nx;
  logic [2:0]        sub, sub_nx;
  logic              hs;
  logic [WORD_W-1:0] cal_dout;
  logic [3:0]        nib;
  logic [COEF_W-1:0] sext;
  logic [COEF_W-1:0] coef;

  assign hs = bus.din_valid & bus.din_ready;

  cbd2_cal u_cal (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (hs),
    .din   (bus.din),
    .dout  (cal_dout)
  );

  assign nib  = 4'(cal_dout >> cbd2_nib_pos(sub));
  assign sext = {{(COEF_W-4){nib[3]}}, nib};

`ifdef CBD2_MODQ_EN
  // Adding Q modulo 2^COEF_W maps -1/-2 onto Q-1/Q-2.
  assign coef = nib[3] ? sext + COEF_W'(KYBER_Q) : sext;
`else
  assign coef = sext;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      word  <= '0;
      sub   <= '0;
    end else begin
      state <= state_nx;
      word  <= word_nx;
      sub   <= sub_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    word_nx       = word;
    sub_nx        = sub;
    bus.busy      = (state != ST_IDLE);
    bus.done      = 1'b0;
    bus.din_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_FETCH;
          word_nx  = '0;
          sub_nx   = '0;
        end
      end

      ST_FETCH: begin
        bus.din_ready = 1'b1;
        if (bus.din_valid) begin
          state_nx = ST_EMIT;
          sub_nx   = '0;
        end
      end

      ST_EMIT: begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = {word, sub};
        bus.coef_data = coef;
        if (sub != 3'd7) begin
          sub_nx = sub + 3'd1;
        end else if (word == 5'(CBD2_WORDS - 1)) begin
          state_nx = ST_DONE;
        end else begin
          // Last slot of a word also accepts the next word so emission runs without a bubble.
          bus.din_ready = 1'b1;
          word_nx       = word + 5'd1;
          sub_nx        = '0;
          state_nx      = bus.din_valid ? ST_EMIT : ST_FETCH;
        end
      end

      ST_DONE: begin
        bus.done = 1'b1;
        state_nx = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
